cordic_sqrt_ctrl: RTL

Sequencer for a hyperbolic-vectoring CORDIC square-root unit built around a single shared 20-bit add/subtract datapath. It loads a fixed-point operand, schedules every x/y update through the one adder (two adder cycles per micro-iteration), applies the mandatory repeat iterations, and optionally performs gain compensation. It sits between the register-level start/done interface and the adder slice, so the square-root function needs only one adder instead of two.

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_addsub.sv | 13 +
 rtl/cordic_sqrt_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and Q4.16 constants for the CORDIC square-root sequencer.
// CORDIC_GAIN_COMP_EN adds the GAIN state and its shift list.
package cordic_pkg;

  localparam int W = 20;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LDX,
    S_LDY,
    S_ITY,
    S_ITX,
    S_GAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LDX,
    S_LDY,
    S_ITY,
    S_ITX
  } state_t;
`endif

  localparam logic [W-1:0] QUARTER  = 20'h04000;
  localparam logic [W-1:0] RANGE_LO = 20'h007AE;
  localparam logic [W-1:0] RANGE_HI = 20'h20000;

  // Hyperbolic CORDIC must run these shifts twice to converge.
  localparam logic [4:0] REP_A = 5'd4;
  localparam logic [4:0] REP_B = 5'd13;

  localparam logic [2:0] GAIN_STEPS = 3'd5;

  // 1/K_h ~= 1 + 2^-3 + 2^-4 + 2^-6 + 2^-8 + 2^-11
  function automatic logic [4:0] gain_shift(input logic [2:0] idx);
    case (idx)
      3'd0:    return 5'd3;
      3'd1:    return 5'd4;
      3'd2:    return 5'd6;
      3'd3:    return 5'd8;
      default: return 5'd11;
    endcase
  endfunction

endpackage

// File: rtl/cordic_addsub.sv
// Single shared 20-bit add/subtract slice; all operand muxing is done by the caller.
module cordic_addsub
  import cordic_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_out
);

  assign o_out = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/cordic_sqrt_ctrl.sv
// Hyperbolic-vectoring CORDIC square root sequenced through one shared adder.
// Define CORDIC_GAIN_COMP_EN to append five shift-add cycles that remove the K_h gain.
module cordic_sqrt_ctrl
  import cordic_pkg::*;
#(
  parameter int ITER = 14
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         range_err
);

  localparam logic [4:0] ITER_L = 5'(ITER);

  state_t              r_state;
  state_t              w_state_next;

  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_y;
  logic signed [W-1:0] r_tmp;
  logic        [W-1:0] r_din;
  logic        [4:0]   r_shift;
  logic                r_rep;
  logic                r_err_pend;
  logic                r_done;
  logic        [W-1:0] r_result;
  logic                r_range_err;
`ifdef CORDIC_GAIN_COMP_EN
  logic        [2:0]   r_gidx;
  logic signed [W-1:0] w_g_sh;
`endif

  logic        [W-1:0] w_a;
  logic        [W-1:0] w_b;
  logic                w_sub;
  logic        [W-1:0] w_sum;
  logic                w_finish;
  logic                w_is_rep;
  logic                w_last_micro;
  logic signed [W-1:0] w_x_sh;
  logic signed [W-1:0] w_y_sh;

  cordic_addsub u_addsub (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_sub (w_sub),
    .o_out (w_sum)
  );

  assign w_x_sh       = r_x >>> r_shift;
  assign w_y_sh       = r_y >>> r_shift;
  assign w_is_rep     = (r_shift == REP_A) || (r_shift == REP_B);
  // The last micro-iteration is shift ITER once any pending repeat of it is done.
  assign w_last_micro = (r_shift == ITER_L) && !(w_is_rep && !r_rep);
`ifdef CORDIC_GAIN_COMP_EN
  assign w_g_sh       = r_x >>> gain_shift(r_gidx);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_a          = r_x;
    w_b          = '0;
    w_sub        = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_LDX;
        end
      end
      S_LDX: begin
        w_a          = r_din;
        w_b          = QUARTER;
        w_state_next = S_LDY;
      end
      S_LDY: begin
        w_a          = r_din;
        w_b          = QUARTER;
        w_sub        = 1'b1;
        w_state_next = S_ITY;
      end
      S_ITY: begin
        w_a          = r_y;
        w_b          = w_x_sh;
        w_sub        = !r_y[W-1];
        w_state_next = S_ITX;
      end
      S_ITX: begin
        w_a   = r_x;
        w_b   = w_y_sh;
        w_sub = !r_y[W-1];
        if (w_last_micro) begin
`ifdef CORDIC_GAIN_COMP_EN
          w_state_next = S_GAIN;
`else
          w_state_next = S_IDLE;
          w_finish     = 1'b1;
`endif
        end else begin
          w_state_next = S_ITY;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_GAIN: begin
        // First step seeds the accumulator with x itself.
        w_a = (r_gidx == 3'd0) ? r_x : r_tmp;
        w_b = w_g_sh;
        if (r_gidx == GAIN_STEPS - 3'd1) begin
          w_state_next = S_IDLE;
          w_finish     = 1'b1;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_tmp       <= '0;
      r_din       <= '0;
      r_shift     <= 5'd1;
      r_rep       <= 1'b0;
      r_err_pend  <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_range_err <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
      r_gidx      <= '0;
`endif
    end else begin
      r_done <= w_finish;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_din      <= din;
            r_err_pend <= (din < RANGE_LO) || (din >= RANGE_HI);
          end
        end
        S_LDX: r_x   <= w_sum;
        S_LDY: r_y   <= w_sum;
        S_ITY: r_tmp <= w_sum;
        S_ITX: begin
          r_x <= w_sum;
          r_y <= r_tmp;
          if (w_last_micro) begin
            r_shift <= 5'd1;
            r_rep   <= 1'b0;
          end else if (w_is_rep && !r_rep) begin
            r_rep <= 1'b1;
          end else begin
            r_shift <= r_shift + 5'd1;
            r_rep   <= 1'b0;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_GAIN: begin
          r_tmp  <= w_sum;
          r_gidx <= (r_gidx == GAIN_STEPS - 3'd1) ? 3'd0 : r_gidx + 3'd1;
        end
`endif
        default: ;
      endcase
      if (w_finish) begin
        r_result    <= w_sum;
        r_range_err <= r_err_pend;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign range_err = r_range_err;

endmodule
